// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
// Round-robin sequencer in front of one shared 3-bit Gray step counter.
// Two clients each request N counter advances, optionally starting from a
// cleared counter. Per job the block returns the final Gray code and a flag
// telling whether the counter wrapped 3'b100 -> 3'b000 during the job.
// Optional build macro GRAY_STEP_CHECK_EN adds an err output that flags any
// counter code change other than a single-bit step after an enabled cycle.
module gray_step_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             clr0,
  input  logic             clr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [2:0]       res_code,
  output logic             res_wrap,
  output logic             busy,
  output logic             cnt_en,
  output logic             cnt_rst,
  input  logic [2:0]       cnt_code
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             gsel, gsel_nxt;
  logic             last_srv, last_srv_nxt;
  logic [LEN_W-1:0] len_cnt, len_cnt_nxt;
  logic             wrap_nxt;
  logic [2:0]       code_nxt;
  logic             win1;
  logic [LEN_W-1:0] sel_len;
  logic             sel_clr;

  // Arbitration: on a tie the requester that was not served last wins.
  always_comb begin
    win1    = req1 && (!req0 || !last_srv);
    sel_len = win1 ? len1 : len0;
    sel_clr = win1 ? clr1 : clr0;
  end

  // Next-state logic and job bookkeeping (step down-counter, wrap, result).
  always_comb begin
    state_nxt    = state;
    gsel_nxt     = gsel;
    last_srv_nxt = last_srv;
    len_cnt_nxt  = len_cnt;
    wrap_nxt     = res_wrap;
    code_nxt     = res_code;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gsel_nxt     = win1;
          last_srv_nxt = win1;
          len_cnt_nxt  = sel_len;
          wrap_nxt     = 1'b0;
          if (sel_clr)
            state_nxt = CLR;
          else if (sel_len == '0)
            state_nxt = SETTLE;
          else
            state_nxt = RUN;
        end
      end
      CLR: begin
        state_nxt = (len_cnt == '0) ? SETTLE : RUN;
      end
      RUN: begin
        // The counter steps 3'b100 -> 3'b000 at the end of this cycle.
        if (cnt_code == 3'b100)
          wrap_nxt = 1'b1;
        len_cnt_nxt = len_cnt - LEN_W'(1);
        if (len_cnt == LEN_W'(1))
          state_nxt = SETTLE;
      end
      SETTLE: begin
        // Counter output now reflects the last enabled step.
        code_nxt  = cnt_code;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and job registers; Reset aborts a job in flight without a done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      gsel     <= 1'b0;
      last_srv <= 1'b1;
      len_cnt  <= '0;
      res_wrap <= 1'b0;
      res_code <= 3'b000;
    end else begin
      state    <= state_nxt;
      gsel     <= gsel_nxt;
      last_srv <= last_srv_nxt;
      len_cnt  <= len_cnt_nxt;
      res_wrap <= wrap_nxt;
      res_code <= code_nxt;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy    = (state != IDLE);
    gnt0    = busy && !gsel;
    gnt1    = busy && gsel;
    done0   = (state == DONE) && !gsel;
    done1   = (state == DONE) && gsel;
    cnt_en  = (state == RUN);
    cnt_rst = (state == CLR);
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [2:0] prev_code;
  logic       prev_run;
  logic       prev_clr;
  logic       chk_vld;
  logic       step_bad;

  function automatic logic one_bit_diff(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] d;
    d = a ^ b;
    return (d != 3'b000) && ((d & (d - 3'd1)) == 3'b000);
  endfunction

  // A stepped cycle must change exactly one bit; otherwise the code must hold,
  // except right after a counter clear.
  always_comb begin
    step_bad = 1'b0;
    if (chk_vld) begin
      if (prev_run)
        step_bad = !one_bit_diff(cnt_code, prev_code);
      else if (!prev_clr)
        step_bad = (cnt_code != prev_code);
    end
  end

  // Previous counter code, sampled every cycle.
  always_ff @(posedge Clk) begin
    prev_code <= cnt_code;
  end

  // Checker control; the first cycle after Reset only primes prev_code.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err      <= 1'b0;
      chk_vld  <= 1'b0;
      prev_run <= 1'b0;
      prev_clr <= 1'b0;
    end else begin
      chk_vld  <= 1'b1;
      prev_run <= (state == RUN);
      prev_clr <= (state == CLR);
      if (step_bad)
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: a Gray step counter model drives cnt_code,
// and each job result is predicted from a step-index model of the counter.
module tb_gray_step_arbiter;
  localparam int LEN_W = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             req0, req1;
  logic [LEN_W-1:0] len0, len1;
  logic             clr0, clr1;
  logic             gnt0, gnt1, done0, done1;
  logic [2:0]       res_code;
  logic             res_wrap;
  logic             busy, cnt_en, cnt_rst;
  logic [2:0]       cnt_code;
`ifdef GRAY_STEP_CHECK_EN
  logic             err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // reference state: counter step index and last served requester
  int exp_idx    = 0;
  int last_srv_m = 1;

  gray_step_arbiter #(.LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1), .clr0(clr0), .clr1(clr1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res_code(res_code), .res_wrap(res_wrap), .busy(busy),
    .cnt_en(cnt_en), .cnt_rst(cnt_rst), .cnt_code(cnt_code)
`ifdef GRAY_STEP_CHECK_EN
    , .err(err)
`endif
  );

  always #5 Clk = ~Clk;

  // Gray step counter model: index 0..7 mapped to reflected binary Gray code.
  int unsigned cidx = 0;
  logic [2:0]  flip = 3'b000;

  function automatic logic [2:0] gray_of(input int unsigned i);
    logic [2:0] b;
    b = 3'(i % 8);
    return b ^ (b >> 1);
  endfunction

  always @(posedge Clk) begin
    if (Reset || cnt_rst) cidx <= 0;
    else if (cnt_en)      cidx <= (cidx + 1) % 8;
  end

  assign cnt_code = gray_of(cidx) ^ flip;

  // Expected result of a job of len steps, updating the reference counter.
  task automatic model_job(input int len, input bit clr, output logic [2:0] c, output logic w);
    int s;
    s       = clr ? 0 : exp_idx;
    w       = ((s + len) >= 8);
    exp_idx = (s + len) % 8;
    c       = gray_of(exp_idx);
  endtask

  // Expected winner given the set of requesters present in IDLE.
  task automatic model_arb(input bit r0, input bit r1, output int w);
    if (r0 && r1) w = 1 - last_srv_m;
    else          w = r1 ? 1 : 0;
    last_srv_m = w;
  endtask

  // Observe one job: granted requester, grant-to-done cycles, enable/clear cycles.
  task automatic collect_job(output int who, output int lat, output int en_n,
                             output int rst_n, output logic [2:0] code, output logic wrap);
    int gn;
    bit got;
    who = -1; lat = -1; en_n = 0; rst_n = 0; code = 3'bxxx; wrap = 1'bx;
    gn = -1; got = 0;
    for (int n = 0; n < 80 && !got; n++) begin
      @(negedge Clk);
      if (gn < 0 && (gnt0 || gnt1)) gn = n;
      if (cnt_en)  en_n++;
      if (cnt_rst) rst_n++;
      if (done0 || done1) begin
        who  = done1 ? 1 : 0;
        lat  = (gn < 0) ? -1 : n - gn;
        code = res_code;
        wrap = res_wrap;
        got  = 1;
      end
    end
  endtask

  task automatic reset_pulse;
    @(negedge Clk);
    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    exp_idx = 0;
    last_srv_m = 1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    len0 = '0; len1 = '0; clr0 = 1'b0; clr1 = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    vectors++;
    if ({busy, gnt0, gnt1, done0, done1} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/gnt/done=%b expected 00000", {busy, gnt0, gnt1, done0, done1});
    end
    vectors++;
    if ({cnt_en, cnt_rst} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_cnt: en/rst=%b expected 00", {cnt_en, cnt_rst});
    end
    vectors++;
    if ({res_wrap, res_code} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_res: wrap,code=%b expected 0000", {res_wrap, res_code});
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    exp_idx = 0;
    last_srv_m = 1;
    repeat (2) @(negedge Clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: busy=%b expected 0", busy);
    end
  endtask

  // Single-requester jobs: clear+3, clear+9 (wraps), 3 from carried state, len 0 at 110.
  task automatic test_single_jobs;
    int tw[4] = '{0, 1, 1, 0};
    int tl[4] = '{3, 9, 3, 0};
    int tc[4] = '{1, 1, 0, 0};
    int who, lat, en_n, rst_n, ew;
    logic [2:0] code, ec;
    logic wrap, ewr;
    for (int i = 0; i < 4; i++) begin
      if (tw[i] == 0) begin req0 = 1'b1; len0 = LEN_W'(tl[i]); clr0 = tc[i][0]; end
      else            begin req1 = 1'b1; len1 = LEN_W'(tl[i]); clr1 = tc[i][0]; end
      model_arb(tw[i] == 0, tw[i] == 1, ew);
      model_job(tl[i], tc[i][0], ec, ewr);
      collect_job(who, lat, en_n, rst_n, code, wrap);
      req0 = 1'b0; req1 = 1'b0;
      vectors++;
      if (who !== ew) begin miscompares++; $display("FAIL single%0d_who: got %0d expected %0d", i, who, ew); end
      vectors++;
      if (lat !== tc[i] + tl[i] + 1) begin miscompares++; $display("FAIL single%0d_lat: got %0d expected %0d", i, lat, tc[i] + tl[i] + 1); end
      vectors++;
      if (en_n !== tl[i]) begin miscompares++; $display("FAIL single%0d_en: got %0d expected %0d", i, en_n, tl[i]); end
      vectors++;
      if (rst_n !== tc[i]) begin miscompares++; $display("FAIL single%0d_rst: got %0d expected %0d", i, rst_n, tc[i]); end
      vectors++;
      if (code !== ec) begin miscompares++; $display("FAIL single%0d_code: got %b expected %b", i, code, ec); end
      vectors++;
      if (wrap !== ewr) begin miscompares++; $display("FAIL single%0d_wrap: got %b expected %b", i, wrap, ewr); end
    end
  endtask

  // Simultaneous requests held high: service alternates starting with requester 0.
  task automatic test_tie;
    int who, lat, en_n, rst_n, ew;
    logic [2:0] code, ec;
    logic wrap, ewr;
    reset_pulse();
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2; clr0 = 1'b1; clr1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      model_arb(1'b1, 1'b1, ew);
      model_job(2, 1'b1, ec, ewr);
      collect_job(who, lat, en_n, rst_n, code, wrap);
      vectors++;
      if (who !== ew) begin miscompares++; $display("FAIL tie%0d_who: got %0d expected %0d", j, who, ew); end
      vectors++;
      if (code !== ec) begin miscompares++; $display("FAIL tie%0d_code: got %b expected %b", j, code, ec); end
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL tie%0d_lat: got %0d expected 4", j, lat); end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Random job mixes: one or both requesters, random lengths and clear flags.
  task automatic test_random;
    int who, lat, en_n, rst_n, ew, jl, jc, njobs;
    int l[2], c[2];
    bit r[2];
    logic [2:0] code, ec;
    logic wrap, ewr;
    for (int it = 0; it < 25; it++) begin
      int m;
      m = $urandom_range(1, 3);
      r[0] = m[0]; r[1] = m[1];
      for (int k = 0; k < 2; k++) begin
        l[k] = $urandom_range(0, 15);
        c[k] = $urandom_range(0, 1);
      end
      len0 = LEN_W'(l[0]); clr0 = c[0][0]; req0 = r[0];
      len1 = LEN_W'(l[1]); clr1 = c[1][0]; req1 = r[1];
      njobs = (r[0] && r[1]) ? 2 : 1;
      for (int j = 0; j < njobs; j++) begin
        model_arb(r[0], r[1], ew);
        jl = l[ew]; jc = c[ew];
        model_job(jl, jc[0], ec, ewr);
        collect_job(who, lat, en_n, rst_n, code, wrap);
        r[ew] = 1'b0;
        if (ew == 0) req0 = 1'b0; else req1 = 1'b0;
        vectors++;
        if (who !== ew) begin miscompares++; $display("FAIL rnd%0d_who: got %0d expected %0d", it, who, ew); end
        vectors++;
        if (lat !== jc + jl + 1) begin miscompares++; $display("FAIL rnd%0d_lat: got %0d expected %0d", it, lat, jc + jl + 1); end
        vectors++;
        if (en_n !== jl || rst_n !== jc) begin miscompares++; $display("FAIL rnd%0d_steps: en=%0d rst=%0d expected en=%0d rst=%0d", it, en_n, rst_n, jl, jc); end
        vectors++;
        if (code !== ec || wrap !== ewr) begin miscompares++; $display("FAIL rnd%0d_res: code=%b wrap=%b expected code=%b wrap=%b", it, code, wrap, ec, ewr); end
      end
    end
  endtask

  // Reset in the middle of a running job aborts it silently.
  task automatic test_reset_midjob;
    int seen, dn;
    req0 = 1'b1; len0 = 4'd7; clr0 = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && seen < 3; n++) begin
      @(negedge Clk);
      if (cnt_en) seen++;
    end
    vectors++;
    if (seen !== 3) begin miscompares++; $display("FAIL mid_run: enable cycles seen %0d expected 3", seen); end
    Reset = 1'b1; req0 = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({busy, gnt0, gnt1, cnt_en, done0, done1} !== 6'b0) begin
      miscompares++;
      $display("FAIL mid_abort: busy/gnt/en/done=%b expected 000000", {busy, gnt0, gnt1, cnt_en, done0, done1});
    end
    vectors++;
    if (res_code !== 3'b000) begin miscompares++; $display("FAIL mid_code: got %b expected 000", res_code); end
    Reset = 1'b0;
    exp_idx = 0;
    last_srv_m = 1;
    dn = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge Clk);
      if (done0 || done1 || busy) dn++;
    end
    vectors++;
    if (dn !== 0) begin miscompares++; $display("FAIL mid_nodone: activity cycles %0d expected 0", dn); end
  endtask

`ifdef GRAY_STEP_CHECK_EN
  // Step-integrity checker: clean jobs leave err low, a two-bit jump sets it.
  task automatic test_checker;
    int who, lat, en_n, rst_n, hit;
    logic [2:0] code;
    logic wrap;
    reset_pulse();
    req0 = 1'b1; len0 = 4'd3; clr0 = 1'b1;
    collect_job(who, lat, en_n, rst_n, code, wrap);
    req0 = 1'b0;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL chk_clean: err=%b expected 0", err); end
    req0 = 1'b1;
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge Clk);
      if (cnt_en && cnt_code == 3'b011) begin
        flip = 3'b001;
        hit  = 1;
      end
    end
    @(posedge Clk);
    #1 flip = 3'b000;
    @(negedge Clk);
    vectors++;
    if (err !== 1'b1 || hit !== 1) begin miscompares++; $display("FAIL chk_set: err=%b hit=%0d expected err=1 hit=1", err, hit); end
    collect_job(who, lat, en_n, rst_n, code, wrap);
    req0 = 1'b0;
    repeat (3) @(negedge Clk);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL chk_hold: err=%b expected 1", err); end
    reset_pulse();
    @(negedge Clk);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL chk_reset: err=%b expected 0", err); end
    req1 = 1'b1; len1 = 4'd11; clr1 = 1'b0;
    collect_job(who, lat, en_n, rst_n, code, wrap);
    req1 = 1'b0;
    repeat (2) @(negedge Clk);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL chk_clean2: err=%b expected 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_jobs();
    test_tie();
    test_random();
    test_reset_midjob();
`ifdef GRAY_STEP_CHECK_EN
    test_checker();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "time limit");
  end

endmodule
